// File: rtl/mdio_responder_if.sv
// MDIO responder bus bundle.
// Groups the management pads, the PHY-status input and the write/error side-band outputs.
//   mdc       : management clock from the initiator (asynchronous to clk)
//   mdio_in   : MDIO pad input
//   mdio_out  : MDIO drive value
//   mdio_oen  : MDIO output enable, active-low (1 = tristate)
//   link_up   : link status reflected in reg1 bit 2
//   wr_strobe : 1-cycle pulse on a committed write to an implemented register
//   wr_addr   : register address of the last committed write
//   wr_data   : data of the last committed write
//   frame_err : 1-cycle pulse on an invalid ST or OP field
// Modports: slave = the responder, master = the initiator/environment side.
interface mdio_responder_if;
  logic        mdc;
  logic        mdio_in;
  logic        mdio_out;
  logic        mdio_oen;
  logic        link_up;
  logic        wr_strobe;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;
  logic        frame_err;

  modport slave (
    input  mdc, mdio_in, link_up,
    output mdio_out, mdio_oen, wr_strobe, wr_addr, wr_data, frame_err
  );

  modport master (
    output mdc, mdio_in, link_up,
    input  mdio_out, mdio_oen, wr_strobe, wr_addr, wr_data, frame_err
  );
endinterface

// File: rtl/mdio_responder.sv
// Clause 22 MDIO management responder (PHY side) with a small register bank.
// MDC and MDIO are oversampled in the clk domain; MDC is never used as a clock.
// Ports:
//   clk : system clock, at least 8x the MDC frequency
//   rst : asynchronous, active-high reset
//   bus : mdio_responder_if.slave (mdc/mdio pads, link_up, write and error side-band)
// Register map: reg0 R/W (bit 15 self-clearing soft reset), reg1 status, reg2/3 PHY ID,
// reg4..NUM_REGS-1 R/W. Unimplemented addresses read 0 and ignore writes.
module mdio_responder #(
  parameter logic [4:0]  PHY_ADDR     = 5'd1,
  parameter logic [15:0] PHY_ID1      = 16'h0141,
  parameter logic [15:0] PHY_ID2      = 16'h0CC2,
  parameter int unsigned NUM_REGS     = 8,
  parameter int unsigned PREAMBLE_MIN = 32,
  parameter int unsigned TIMEOUT_CYC  = 4096
) (
  input logic             clk,
  input logic             rst,
  mdio_responder_if.slave bus
);

  localparam int unsigned CntW = ($clog2(PREAMBLE_MIN + 1) > 5) ? $clog2(PREAMBLE_MIN + 1) : 5;
  localparam int unsigned ToW  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CntW-1:0] PreMax = CntW'(PREAMBLE_MIN);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  typedef enum logic [2:0] {
    StIdle, StSt, StOp, StPhyad, StRegad, StTa, StData, StSkip
  } state_e;

  // Synchronizers; mdc flops reset high so a high idle MDC at reset release is not an edge.
  logic [1:0] mdc_sync_q, mdio_sync_q;
  logic       mdc_prev_q;
  logic       evt, bit_in;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [4:0]      addr_sh_q, addr_sh_d;
  logic [15:0]     data_sh_q, data_sh_d;
  logic            is_read_q, is_read_d;
  logic            op_hi_q, op_hi_d;
  logic            out_q, out_d;
  logic            oen_q, oen_d;
  logic            wr_strobe_q, wr_strobe_d;
  logic [4:0]      wr_addr_q, wr_addr_d;
  logic [15:0]     wr_data_q, wr_data_d;
  logic            frame_err_q, frame_err_d;
  logic [ToW-1:0]  to_q, to_d;
  logic            timeout;

  logic [15:0] regs_q [NUM_REGS];
  logic        reg_wr_en, reg_restore;
  logic [15:0] commit_word;
  logic [4:0]  rd_addr;
  logic [15:0] rd_word;

  assign evt    = mdc_sync_q[1] & ~mdc_prev_q;
  assign bit_in = mdio_sync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mdc_sync_q  <= 2'b11;
      mdc_prev_q  <= 1'b1;
      mdio_sync_q <= 2'b11;
    end else begin
      mdc_sync_q  <= {mdc_sync_q[0], bus.mdc};
      mdc_prev_q  <= mdc_sync_q[1];
      mdio_sync_q <= {mdio_sync_q[0], bus.mdio_in};
    end
  end

  // Read mux; address includes the REGAD bit being sampled this cycle.
  always_comb begin
    rd_addr = {addr_sh_q[3:0], bit_in};
    rd_word = '0;
    if (rd_addr == 5'd0) begin
      rd_word = regs_q[0];
    end else if (rd_addr == 5'd1) begin
      rd_word = {13'b0, bus.link_up, 2'b0};
    end else if (rd_addr == 5'd2) begin
      rd_word = PHY_ID1;
    end else if (rd_addr == 5'd3) begin
      rd_word = PHY_ID2;
    end else begin
      for (int i = 4; i < int'(NUM_REGS); i++) begin
        if (rd_addr == 5'(i)) rd_word = regs_q[i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_sh_d   = addr_sh_q;
    data_sh_d   = data_sh_q;
    is_read_d   = is_read_q;
    op_hi_d     = op_hi_q;
    out_d       = out_q;
    oen_d       = oen_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    frame_err_d = 1'b0;
    to_d        = to_q;
    timeout     = 1'b0;
    reg_wr_en   = 1'b0;
    reg_restore = 1'b0;
    commit_word = {data_sh_q[14:0], bit_in};

    if (state_q == StIdle || evt) begin
      to_d = '0;
    end else if (to_q == ToW'(TIMEOUT_CYC - 1)) begin
      to_d    = '0;
      timeout = 1'b1;
    end else begin
      to_d = to_q + ToW'(1);
    end

    if (timeout) begin
      state_d = StIdle;
      cnt_d   = '0;
      oen_d   = 1'b1;
      out_d   = 1'b1;
    end else if (evt) begin
      unique case (state_q)
        StIdle: begin
          if (bit_in) begin
            if (cnt_q != PreMax) cnt_d = cnt_q + CntOne;
          end else if (cnt_q == PreMax) begin
            state_d = StSt;  // this 0 is the first ST bit
          end else begin
            cnt_d = '0;
          end
        end
        StSt: begin
          cnt_d = '0;
          if (bit_in) begin
            state_d = StOp;
          end else begin
            frame_err_d = 1'b1;
            state_d     = StIdle;
          end
        end
        StOp: begin
          if (cnt_q == '0) begin
            op_hi_d = bit_in;
            cnt_d   = CntOne;
          end else begin
            cnt_d = '0;
            if (op_hi_q != bit_in) begin
              is_read_d = op_hi_q;  // 10 = read, 01 = write
              state_d   = StPhyad;
            end else begin
              frame_err_d = 1'b1;
              state_d     = StSkip;
            end
          end
        end
        StPhyad: begin
          addr_sh_d = {addr_sh_q[3:0], bit_in};
          if (cnt_q == CntW'(4)) begin
            cnt_d   = '0;
            state_d = (addr_sh_d == PHY_ADDR) ? StRegad : StSkip;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
        StRegad: begin
          addr_sh_d = {addr_sh_q[3:0], bit_in};
          if (cnt_q == CntW'(4)) begin
            cnt_d     = '0;
            data_sh_d = rd_word;  // snapshot, including link_up
            state_d   = StTa;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
        StTa: begin
          if (cnt_q == '0) begin
            cnt_d = CntOne;
            if (is_read_q) begin
              oen_d = 1'b0;
              out_d = 1'b0;
            end
          end else begin
            cnt_d   = '0;
            state_d = StData;
            if (is_read_q) begin
              out_d     = data_sh_q[15];
              data_sh_d = {data_sh_q[14:0], 1'b0};
            end
          end
        end
        StData: begin
          if (is_read_q) begin
            if (cnt_q == CntW'(15)) begin
              oen_d   = 1'b1;
              out_d   = 1'b1;
              cnt_d   = '0;
              state_d = StIdle;
            end else begin
              out_d     = data_sh_q[15];
              data_sh_d = {data_sh_q[14:0], 1'b0};
              cnt_d     = cnt_q + CntOne;
            end
          end else begin
            data_sh_d = commit_word;
            if (cnt_q == CntW'(15)) begin
              cnt_d   = '0;
              state_d = StIdle;
              if (32'(addr_sh_q) < NUM_REGS) begin
                wr_strobe_d = 1'b1;
                wr_addr_d   = addr_sh_q;
                wr_data_d   = commit_word;
                if (addr_sh_q == 5'd0) begin
                  if (commit_word[15]) reg_restore = 1'b1;
                  else                 reg_wr_en   = 1'b1;
                end else if (addr_sh_q >= 5'd4) begin
                  reg_wr_en = 1'b1;
                end
              end
            end else begin
              cnt_d = cnt_q + CntOne;
            end
          end
        end
        StSkip: begin
          // TA + DATA bits of a frame not addressed to us
          if (cnt_q == CntW'(17)) begin
            cnt_d   = '0;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      addr_sh_q   <= '0;
      data_sh_q   <= '0;
      is_read_q   <= 1'b0;
      op_hi_q     <= 1'b0;
      out_q       <= 1'b1;
      oen_q       <= 1'b1;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      frame_err_q <= 1'b0;
      to_q        <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_sh_q   <= addr_sh_d;
      data_sh_q   <= data_sh_d;
      is_read_q   <= is_read_d;
      op_hi_q     <= op_hi_d;
      out_q       <= out_d;
      oen_q       <= oen_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      frame_err_q <= frame_err_d;
      to_q        <= to_d;
    end
  end

  // Register bank; entries 1..3 are computed on read and never stored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
    end else if (reg_restore) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
    end else if (reg_wr_en) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        if ((i == 0 || i >= 4) && addr_sh_q == 5'(i)) regs_q[i] <= commit_word;
      end
    end
  end

  assign bus.mdio_out  = out_q;
  assign bus.mdio_oen  = oen_q;
  assign bus.wr_strobe = wr_strobe_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_mdio_responder.sv
// Randomized bench for mdio_responder: frames are built bit by bit, the pad is modelled as an
// open-drain line with pull-up, and a register-map model predicts read data and write commits.
module tb_mdio_responder;
  localparam logic [4:0]  PhyAddr    = 5'd1;
  localparam logic [15:0] PhyId1     = 16'h0141;
  localparam logic [15:0] PhyId2     = 16'h0CC2;
  localparam int unsigned NumRegs    = 8;
  localparam int unsigned TimeoutCyc = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic drive_en = 1'b1;
  logic drive_val = 1'b1;

  int n_checks = 0;
  int n_errors = 0;
  int strobe_cnt = 0;
  int err_cnt = 0;

  logic [15:0] m_regs [32];
  logic [4:0]  exp_wr_addr;
  logic [15:0] exp_wr_data;

  mdio_responder_if bus ();

  mdio_responder #(
    .PHY_ADDR    (PhyAddr),
    .PHY_ID1     (PhyId1),
    .PHY_ID2     (PhyId2),
    .NUM_REGS    (NumRegs),
    .PREAMBLE_MIN(32),
    .TIMEOUT_CYC (TimeoutCyc)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Open-drain line: DUT drives when enabled, else the bench, else the pull-up.
  assign bus.mdio_in = !bus.mdio_oen ? bus.mdio_out : (drive_en ? drive_val : 1'b1);

  always @(posedge clk) begin
    if (bus.wr_strobe) strobe_cnt <= strobe_cnt + 1;
    if (bus.frame_err) err_cnt <= err_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_read(input logic [4:0] ra, input logic link);
    if (ra == 5'd1) return {13'b0, link, 2'b0};
    if (ra == 5'd2) return PhyId1;
    if (ra == 5'd3) return PhyId2;
    if (32'(ra) < NumRegs) return m_regs[ra];
    return 16'h0000;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 16'h0000;
    exp_wr_addr = '0;
    exp_wr_data = '0;
  endtask

  task automatic send_bit(input logic drv, input logic b, output logic o, output logic d);
    drive_en  = drv;
    drive_val = b;
    bus.mdc   = 1'b0;
    repeat (5) @(negedge clk);
    bus.mdc = 1'b1;
    repeat (5) @(negedge clk);
    o = bus.mdio_oen;
    d = bus.mdio_out;
  endtask

  task automatic run_frame(input int pre, input logic [1:0] st, input logic [1:0] op,
                           input logic [4:0] phy, input logic [4:0] ra, input logic [15:0] wd,
                           input int nbits, output logic [31:0] oen_v, output logic [31:0] out_v);
    logic [31:0] bits;
    logic o, d;
    bits  = {st, op, phy, ra, 2'b10, wd};
    oen_v = '1;
    out_v = '1;
    for (int i = 0; i < pre; i++) send_bit(1'b1, 1'b1, o, d);
    for (int i = 0; i < nbits; i++) begin
      send_bit((i < 14) || (op == 2'b01), bits[31-i], o, d);
      oen_v[i] = o;
      out_v[i] = d;
    end
  endtask

  // Full frame with model prediction; returns the word the DUT drove in the read data slots.
  task automatic full_frame(input string tag, input int pre, input logic [1:0] st,
                            input logic [1:0] op, input logic [4:0] phy, input logic [4:0] ra,
                            input logic [15:0] wd, output logic [15:0] rd_obs);
    logic [31:0] oen_v, out_v, exp_oen, exp_out;
    logic [15:0] rdv;
    int s0, e0, exp_s, exp_e;
    logic accepted, valid, is_rd;
    bus.link_up = 1'($urandom_range(0, 1));
    s0 = strobe_cnt;
    e0 = err_cnt;
    accepted = (pre >= 32) && (st == 2'b01);
    exp_e = ((pre >= 32) && (st == 2'b00 || (accepted && (op == 2'b00 || op == 2'b11)))) ? 1 : 0;
    valid = accepted && (op == 2'b10 || op == 2'b01) && (phy == PhyAddr);
    is_rd = valid && (op == 2'b10);
    rdv = model_read(ra, bus.link_up);
    run_frame(pre, st, op, phy, ra, wd, 32, oen_v, out_v);
    exp_oen = '1;
    exp_out = '1;
    if (is_rd) begin
      for (int i = 14; i <= 30; i++) begin
        exp_oen[i] = 1'b0;
        exp_out[i] = (i == 14) ? 1'b0 : rdv[30-i];
      end
    end
    exp_s = 0;
    if (valid && op == 2'b01 && 32'(ra) < NumRegs) begin
      exp_s = 1;
      exp_wr_addr = ra;
      exp_wr_data = wd;
      if (ra == 5'd0) begin
        if (wd[15]) for (int i = 0; i < 32; i++) m_regs[i] = 16'h0000;
        else m_regs[0] = wd;
      end else if (ra >= 5'd4) begin
        m_regs[ra] = wd;
      end
    end
    repeat (4) @(negedge clk);
    for (int k = 0; k < 16; k++) rd_obs[15-k] = out_v[15+k];
    check_eq({tag, " oen"}, oen_v, exp_oen);
    check_eq({tag, " out"}, out_v, exp_out);
    check_eq({tag, " strobes"}, 32'(strobe_cnt - s0), 32'(exp_s));
    check_eq({tag, " frame_err"}, 32'(err_cnt - e0), 32'(exp_e));
    check_eq({tag, " wr_addr"}, 32'(bus.wr_addr), 32'(exp_wr_addr));
    check_eq({tag, " wr_data"}, 32'(bus.wr_data), 32'(exp_wr_data));
  endtask

  initial begin
    logic [15:0] rd;
    logic [31:0] oen_v, out_v;
    logic [1:0] st, op;
    logic [4:0] phy, ra;
    logic [15:0] wd;
    bus.mdc = 1'b0;
    bus.link_up = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst oen", 32'(bus.mdio_oen), 32'd1);
    check_eq("rst out", 32'(bus.mdio_out), 32'd1);
    check_eq("rst strobe", 32'(bus.wr_strobe), 32'd0);
    check_eq("rst wr_addr", 32'(bus.wr_addr), 32'd0);
    check_eq("rst wr_data", 32'(bus.wr_data), 32'd0);
    check_eq("rst frame_err", 32'(bus.frame_err), 32'd0);

    full_frame("t1 rd id1", 32, 2'b01, 2'b10, 5'd1, 5'd2, 16'h0, rd);
    check_eq("t1 id1 value", 32'(rd), 32'h0141);
    full_frame("t2 wr r4", 32, 2'b01, 2'b01, 5'd1, 5'd4, 16'hA5A5, rd);
    full_frame("t2 rd r4", 32, 2'b01, 2'b10, 5'd1, 5'd4, 16'h0, rd);
    check_eq("t2 r4 value", 32'(rd), 32'hA5A5);
    full_frame("t3 rd phy3", 32, 2'b01, 2'b10, 5'd3, 5'd2, 16'h0, rd);
    full_frame("t3 rd id2", 32, 2'b01, 2'b10, 5'd1, 5'd3, 16'h0, rd);
    check_eq("t3 id2 value", 32'(rd), 32'h0CC2);
    full_frame("t4 pre31", 31, 2'b01, 2'b10, 5'd1, 5'd2, 16'h0, rd);
    full_frame("t4 st00", 32, 2'b00, 2'b10, 5'd1, 5'd2, 16'h0, rd);
    full_frame("t5 wr r4", 32, 2'b01, 2'b01, 5'd1, 5'd4, 16'hA5A5, rd);
    full_frame("t5 wr r0", 32, 2'b01, 2'b01, 5'd1, 5'd0, 16'h8000, rd);
    full_frame("t5 rd r4", 32, 2'b01, 2'b10, 5'd1, 5'd4, 16'h0, rd);
    check_eq("t5 r4 value", 32'(rd), 32'h0000);
    full_frame("t5 rd r0", 32, 2'b01, 2'b10, 5'd1, 5'd0, 16'h0, rd);
    check_eq("t5 r0 value", 32'(rd), 32'h0000);

    for (int n = 0; n < 30; n++) begin
      st  = ($urandom_range(0, 7) == 0) ? 2'b00 : 2'b01;
      op  = 2'($urandom_range(0, 3));
      phy = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : PhyAddr;
      ra  = 5'($urandom_range(0, 9));
      wd  = 16'($urandom);
      if (ra == 5'd0) wd[15] = ($urandom_range(0, 3) == 0);
      full_frame("rnd", 32 + int'($urandom_range(0, 3)), st, op, phy, ra, wd, rd);
    end

    // Timeout: MDC stops in the middle of the read data.
    run_frame(32, 2'b01, 2'b10, 5'd1, 5'd2, 16'h0, 21, oen_v, out_v);
    check_eq("t6 driving before stall", 32'(oen_v[20]), 32'd0);
    bus.mdc = 1'b0;
    repeat (TimeoutCyc + 20) @(negedge clk);
    check_eq("t6 timeout oen", 32'(bus.mdio_oen), 32'd1);
    check_eq("t6 timeout out", 32'(bus.mdio_out), 32'd1);
    full_frame("t6 recover", 32, 2'b01, 2'b10, 5'd1, 5'd2, 16'h0, rd);
    check_eq("t6 recover value", 32'(rd), 32'h0141);

    // Asynchronous reset during a read.
    full_frame("t6 wr r4", 32, 2'b01, 2'b01, 5'd1, 5'd4, 16'h1234, rd);
    run_frame(32, 2'b01, 2'b10, 5'd1, 5'd4, 16'h0, 21, oen_v, out_v);
    check_eq("t6 driving before rst", 32'(oen_v[20]), 32'd0);
    bus.mdc = 1'b0;
    #3 rst = 1'b1;
    #1 check_eq("t6 async rst oen", 32'(bus.mdio_oen), 32'd1);
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    full_frame("t6 rd r4 after rst", 32, 2'b01, 2'b10, 5'd1, 5'd4, 16'h0, rd);
    check_eq("t6 r4 after rst", 32'(rd), 32'h0000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
